load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access initiator between the execute stage and the 64-bit byte-addressed data memory. It accepts one load or store request at a time and drives the memory's address, data and strobe ports. It performs RISC-V size and sign handling (b/h/w/d, unsigned loads) and does read-modify-write for sub-doubleword stores, because the memory always writes 8 bytes. It returns one response per request and flags illegal or out-of-range accesses.

## Interface
- MEM_BYTES, 64, data memory size in bytes; must be ≥ 8.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on `req_valid && req_ready`.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- req_addr  in  64  effective byte address.
- req_wdata  in  64  store data, low bytes used.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  64  load result, 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid.
- Mem_Addr  out  64  memory window base address.
- Write_Data  out  64  full 8-byte write word.
- MemWrite  out  1  write strobe.
- MemRead  out  1  read strobe.
- Read_Data  in  64  memory read word; byte k = mem[Mem_Addr+k].

## Operation
- On accept, latch store, funct3, addr and wdata.
- Access size: n = 1, 2, 4 or 8.
- Window arithmetic, all unsigned 64-bit:
  - base = min(addr, MEM_BYTES−8).
  - off = addr − base, range 0..7.
- Fault conditions:
  - funct3 = 111.
  - A store with funct3[2] = 1.
  - addr + n > MEM_BYTES, checked without overflow by comparing addr > MEM_BYTES − n.
- Fault handling: IDLE→RESP with resp_fault=1; no strobe is ever asserted.
- States: IDLE, RD_REQ, RD_CAP, WR, RESP.
- Transitions:
  - Load: IDLE→RD_REQ→RD_CAP→RESP.
  - Store with n=8: IDLE→WR→RESP.
  - Store with n<8: IDLE→RD_REQ→RD_CAP→WR→RESP.
- RD_REQ and RD_CAP: MemRead=1 and Mem_Addr=base. The read word is registered at the end of RD_CAP.
- Load result: take bytes off..off+n−1 of the captured word. Sign-extend for b/h/w; zero-extend for bu/hu/wu and d.
- WR: MemWrite=1, Mem_Addr=base.
  - Write_Data is the captured word with bytes off..off+n−1 replaced by req_wdata[8n−1:0].
  - For n=8, Write_Data = wdata.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. The response has no backpressure.
- Outside the states listed above, Mem_Addr=0, Write_Data=0 and both strobes are 0.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, MemRead=0, MemWrite=0, Mem_Addr=0, Write_Data=0.
- Cycle N is the cycle in which the request is accepted. resp_valid is high in:
  - N+3 for a load.
  - N+2 for a doubleword store.
  - N+4 for a sub-doubleword store.
  - N+1 for a fault.
- All outputs are registered.
- Reset mid-operation: the unit returns to IDLE on the next edge and no response is issued.
  - If reset lands before WR, no write happens.
  - If reset lands in WR, that one-cycle write has already been presented.
- req_valid outside IDLE is ignored; a new request can be accepted in the cycle after RESP.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a request with addr mod n ≠ 0 faults, with the same handling as any other fault.
- Undefined: misaligned accesses are serviced normally through the window arithmetic.

## Structure
- Package lsu_pkg holds:
  - funct3 constants.
  - The state enum.
  - A size-decode function (funct3 → n, legal flag).
- Sub-module lsu_byte_lane implements byte extract with sign/zero extension and byte merge (captured word, wdata, off, n → Write_Data). It is combinational and instantiated once.
- Bench memory model: 64 bytes, byte i initialised to i unless stated otherwise. Read_Data reflects Mem_Addr while MemRead=1; writes land on the clock edge while MemWrite=1.

## Test plan
- lb addr 5 → resp_rdata 0x05 at N+3, MemRead high in N+1..N+2, Mem_Addr 5.
- mem[10]=0x80:
  - lb addr 10 → 0xFFFFFFFFFFFFFF80.
  - lbu addr 10 → 0x80.
  - lh addr 10 (mem[11]=0x0B) → 0x0B80.
- sh wdata 0xABCD addr 62:
  - Mem_Addr 56, MemWrite at N+3.
  - Afterwards mem[62]=0xCD, mem[63]=0xAB, mem[56..61] unchanged.
  - resp_valid at N+4, no fault.
- Fault cases, each → resp_fault=1 at N+1 with no MemRead or MemWrite:
  - ld addr 60.
  - Store with funct3 100.
  - funct3 111.
- sb addr 3 with reset asserted in RD_CAP:
  - No MemWrite and no resp_valid.
  - req_ready=1 the cycle after reset.
  - Next lb addr 3 → 0x03.
- lw addr 6:
  - With LSU_MISALIGN_TRAP_EN → fault.
  - Without it → 0x09080706.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and the access-size decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_CAP,
    S_WR,
    S_RESP
  } lsu_state_e;

  typedef struct packed {
    logic [3:0] n;
    logic       legal;
  } lsu_size_t;

  // funct3 -> access size in bytes; 111 is the only illegal encoding
  function automatic lsu_size_t size_decode(input logic [2:0] f3);
    lsu_size_t s;
    s.legal = 1'b1;
    case (f3)
      F3_B, F3_BU: s.n = 4'd1;
      F3_H, F3_HU: s.n = 4'd2;
      F3_W, F3_WU: s.n = 4'd4;
      F3_D:        s.n = 4'd8;
      default: begin
        s.n     = 4'd8;
        s.legal = 1'b0;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: extracts a load value with sign/zero extension and
// merges store bytes into a captured 8-byte word.
module lsu_byte_lane (
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [3:0]  n,
  input  logic        sign_ext,
  output logic [63:0] load_val,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] shifted;
  logic [63:0] mask;

  // extract bytes off..off+n-1 and extend, then splice wdata into the word
  always_comb begin
    sh      = {off, 3'b000};
    shifted = word >> sh;
    case (n)
      4'd1: begin
        mask     = 64'h0000_0000_0000_00FF;
        load_val = sign_ext ? {{56{shifted[7]}}, shifted[7:0]} : {56'b0, shifted[7:0]};
      end
      4'd2: begin
        mask     = 64'h0000_0000_0000_FFFF;
        load_val = sign_ext ? {{48{shifted[15]}}, shifted[15:0]} : {48'b0, shifted[15:0]};
      end
      4'd4: begin
        mask     = 64'h0000_0000_FFFF_FFFF;
        load_val = sign_ext ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
      end
      default: begin
        mask     = '1;
        load_val = shifted;
      end
    endcase
    merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with an 8-byte memory window and read-modify-write for
// sub-doubleword stores. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  localparam logic [63:0] MEM_SZ = 64'(MEM_BYTES);

  lsu_state_e  state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q, wdata_q;

  logic        cur_store;
  logic [2:0]  cur_f3;
  logic [63:0] cur_addr, cur_wdata;
  lsu_size_t   sz;
  logic [63:0] n64, base;
  logic [2:0]  off;
  logic        fault;
  logic [63:0] load_val, merged;

  logic        rd_d, wr_d, resp_d, fault_d;
  logic [63:0] addr_d, wdata_d, rdata_d;

  lsu_byte_lane u_lane (
    .word     (Read_Data),
    .wdata    (cur_wdata),
    .off      (off),
    .n        (sz.n),
    .sign_ext (~cur_f3[2]),
    .load_val (load_val),
    .merged   (merged)
  );

  // Outputs are registered, so they are computed from the next state; in IDLE
  // the request fields are used directly because they are not latched yet.
  always_comb begin
    cur_store = (state_q == S_IDLE) ? req_store  : store_q;
    cur_f3    = (state_q == S_IDLE) ? req_funct3 : f3_q;
    cur_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    sz        = size_decode(cur_f3);
    n64       = 64'(sz.n);
    base      = (cur_addr > MEM_SZ - 64'd8) ? MEM_SZ - 64'd8 : cur_addr;
    off       = 3'(cur_addr - base);
    fault     = !sz.legal || (cur_store && cur_f3[2]) || (cur_addr > MEM_SZ - n64);
`ifdef LSU_MISALIGN_TRAP_EN
    fault     = fault || ((cur_addr & (n64 - 64'd1)) != '0);
`endif
  end

  // next-state and next-output decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (fault)                          state_d = S_RESP;
          else if (req_store && sz.n == 4'd8) state_d = S_WR;
          else                                state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: state_d = store_q ? S_WR : S_RESP;
      S_WR:     state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    rd_d    = (state_d == S_RD_REQ) || (state_d == S_RD_CAP);
    wr_d    = (state_d == S_WR);
    resp_d  = (state_d == S_RESP);
    fault_d = (state_q == S_IDLE) && (state_d == S_RESP);
    addr_d  = (rd_d || wr_d) ? base : '0;
    wdata_d = '0;
    if (wr_d) wdata_d = (sz.n == 4'd8) ? cur_wdata : merged;
    rdata_d = '0;
    if (state_q == S_RD_CAP && !store_q) rdata_d = load_val;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // request latch on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      store_q <= req_store;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Mem_Addr   <= '0;
      Write_Data <= '0;
    end else begin
      req_ready  <= (state_d == S_IDLE);
      resp_valid <= resp_d;
      resp_fault <= fault_d;
      resp_rdata <= rdata_d;
      MemRead    <= rd_d;
      MemWrite   <= wr_d;
      Mem_Addr   <= addr_d;
      Write_Data <= wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-byte memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  logic [7:0]  mem [64];
  logic        mem_init;
  logic        poke_en;
  logic [5:0]  poke_a;
  logic [7:0]  poke_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_Data  (Read_Data)
  );

  always_comb begin
    Read_Data = '0;
    if (MemRead)
      for (int k = 0; k < 8; k++)
        if (int'(Mem_Addr) + k < 64) Read_Data[8*k +: 8] = mem[int'(Mem_Addr) + k];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else begin
      if (poke_en) mem[poke_a] <= poke_d;
      if (MemWrite)
        for (int k = 0; k < 8; k++)
          if (int'(Mem_Addr) + k < 64) mem[int'(Mem_Addr) + k] <= Write_Data[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int          r_resp, r_rd_first, r_rd_last, r_wr;
  logic [63:0] r_maddr, r_rdata;
  logic        r_fault;

  // Issue one request, then observe 8 cycles at negedges (k = cycles after N)
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_resp = -1; r_rd_first = -1; r_rd_last = -1; r_wr = -1;
    r_maddr = '0; r_rdata = '1; r_fault = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (MemRead) begin
        if (r_rd_first < 0) r_rd_first = k;
        r_rd_last = k;
        r_maddr = Mem_Addr;
      end
      if (MemWrite) begin
        r_wr = k;
        r_maddr = Mem_Addr;
      end
      if (resp_valid && r_resp < 0) begin
        r_resp = k; r_rdata = resp_rdata; r_fault = resp_fault;
      end
    end
  endtask

  int          seen_wr, seen_resp;

  initial begin
    reset = 1'b1; mem_init = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_fault", 64'(resp_fault), 64'd0);
    chk("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    chk("rst_addr", Mem_Addr, 64'd0);
    chk("rst_wdata", Write_Data, 64'd0);
    reset = 1'b0; mem_init = 1'b0;

    // lb addr 5
    run_req(1'b0, 3'b000, 64'd5, '0);
    chk("lb5_resp_at", 64'(r_resp), 64'd3);
    chk("lb5_rd_first", 64'(r_rd_first), 64'd1);
    chk("lb5_rd_last", 64'(r_rd_last), 64'd2);
    chk("lb5_addr", r_maddr, 64'd5);
    chk("lb5_data", r_rdata, 64'h05);
    chk("lb5_fault", 64'(r_fault), 64'd0);

    // mem[10] = 0x80
    @(negedge clk); poke_en = 1'b1; poke_a = 6'd10; poke_d = 8'h80;
    @(negedge clk); poke_en = 1'b0;
    run_req(1'b0, 3'b000, 64'd10, '0);
    chk("lb10_data", r_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_req(1'b0, 3'b100, 64'd10, '0);
    chk("lbu10_data", r_rdata, 64'h80);
    run_req(1'b0, 3'b001, 64'd10, '0);
    chk("lh10_data", r_rdata, 64'h0B80);

    // sh 0xABCD at 62: window base 56, offset 6
    run_req(1'b1, 3'b001, 64'd62, 64'h1234_ABCD);
    chk("sh62_wr_at", 64'(r_wr), 64'd3);
    chk("sh62_addr", r_maddr, 64'd56);
    chk("sh62_resp_at", 64'(r_resp), 64'd4);
    chk("sh62_fault", 64'(r_fault), 64'd0);
    chk("sh62_rdata", r_rdata, 64'd0);
    chk("sh62_mem62", 64'(mem[62]), 64'hCD);
    chk("sh62_mem63", 64'(mem[63]), 64'hAB);
    for (int i = 56; i < 62; i++) chk("sh62_unchanged", 64'(mem[i]), 64'(i));
    run_req(1'b0, 3'b011, 64'd56, '0);
    chk("ld56_data", r_rdata, 64'hABCD_3D3C_3B3A_3938);

    // sd at 16
    run_req(1'b1, 3'b011, 64'd16, 64'h1122_3344_5566_7788);
    chk("sd16_wr_at", 64'(r_wr), 64'd1);
    chk("sd16_resp_at", 64'(r_resp), 64'd2);
    chk("sd16_rd", 64'(r_rd_first), 64'hFFFF_FFFF_FFFF_FFFF);
    run_req(1'b0, 3'b010, 64'd16, '0);
    chk("lw16_data", r_rdata, 64'h5566_7788);
    run_req(1'b0, 3'b110, 64'd20, '0);
    chk("lwu20_data", r_rdata, 64'h1122_3344);

    // faults
    run_req(1'b0, 3'b011, 64'd60, '0);
    chk("ld60_resp_at", 64'(r_resp), 64'd1);
    chk("ld60_fault", 64'(r_fault), 64'd1);
    chk("ld60_no_strobe", 64'({r_rd_first < 0, r_wr < 0}), 64'd3);
    chk("ld60_rdata", r_rdata, 64'd0);
    run_req(1'b1, 3'b100, 64'd0, 64'hFF);
    chk("sbu_resp_at", 64'(r_resp), 64'd1);
    chk("sbu_fault", 64'(r_fault), 64'd1);
    chk("sbu_no_strobe", 64'({r_rd_first < 0, r_wr < 0}), 64'd3);
    run_req(1'b0, 3'b111, 64'd0, '0);
    chk("f111_resp_at", 64'(r_resp), 64'd1);
    chk("f111_fault", 64'(r_fault), 64'd1);
    chk("f111_no_strobe", 64'({r_rd_first < 0, r_wr < 0}), 64'd3);

    // sb addr 3 with reset landing in RD_CAP
    seen_wr = 0; seen_resp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 64'd3; req_wdata = 64'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (MemWrite) seen_wr++;
    if (resp_valid) seen_resp++;
    @(negedge clk);
    chk("rst_mid_in_rdcap", 64'(MemRead), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (MemWrite) seen_wr++;
      if (resp_valid) seen_resp++;
      @(negedge clk);
    end
    chk("rst_mid_no_write", 64'(seen_wr), 64'd0);
    chk("rst_mid_no_resp", 64'(seen_resp), 64'd0);
    run_req(1'b0, 3'b000, 64'd3, '0);
    chk("lb3_data", r_rdata, 64'h03);

    // lw addr 6 (misaligned)
    run_req(1'b0, 3'b010, 64'd6, '0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw6_fault", 64'(r_fault), 64'd1);
    chk("lw6_resp_at", 64'(r_resp), 64'd1);
`else
    chk("lw6_fault", 64'(r_fault), 64'd0);
    chk("lw6_data", r_rdata, 64'h0908_0706);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
